debounce: RTL

//  Per-bit input conditioner: optionally synchronizes asynchronous inputs, then

---
 rtl/debounce.sv | 51 +++++
 1 files changed

// File: rtl/debounce.sv
// debounce: per-bit level debouncer that accepts a new level after CYCLES consecutive mismatches.
// Define DEBOUNCE_SYNC_EN to add a 2-flop synchronizer per bit ahead of the debouncer.
module debounce #(
  parameter int DW     = 1,
  parameter int CYCLES = 16,
  parameter int CW     = $clog2(CYCLES + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic [DW-1:0] busy
);
  logic [DW-1:0] s;
`ifdef DEBOUNCE_SYNC_EN
  logic [DW-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  assign s = sync2_q;
`else
  assign s = in;
`endif
  for (genvar i = 0; i < DW; i++) begin : g_bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d, busy_q, hit;
    // hit marks the last mismatch of a full run; the count then restarts from zero
    always_comb begin
      hit   = (s[i] != out_q) && (cnt_q == CW'(CYCLES - 1));
      cnt_d = (s[i] != out_q && !hit) ? cnt_q + 1'b1 : '0;
      out_d = hit ? s[i] : out_q;
    end
    always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
        cnt_q  <= '0;
        out_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        busy_q <= |cnt_d;
      end
    assign out[i]  = out_q;
    assign busy[i] = busy_q;
  end
endmodule
